// File: rtl/uart_line_assembler_pkg.sv
// Shared constants and FSM state encoding for the UART line assembler.
package uart_line_assembler_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  localparam int unsigned LINE_COUNT_W = 16;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_RX_GAP  = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_TX_GAP  = 3'd3,
    ST_EOL_CR  = 3'd4,
    ST_EOL_LF  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/uart_line_buffer.sv
// LINE_LEN x DATA_WIDTH line storage: synchronous write, registered synchronous read.
module uart_line_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LINE_LEN   = 64
) (
  input  logic                        clk,
  input  logic                        i_we,
  input  logic [$clog2(LINE_LEN)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]       i_wdata,
  input  logic [$clog2(LINE_LEN)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]       o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [LINE_LEN];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Contents are don't-care after reset, so the array has no reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_line_assembler.sv
// Line-oriented echo: pops RX FIFO characters into a line buffer with backspace
// editing, then writes the line to the TX FIFO on EOL, full buffer or idle timeout.
module uart_line_assembler
  import uart_line_assembler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned LINE_LEN       = 64,
  parameter logic [7:0]  EOL_CHAR       = ASCII_CR,
  parameter logic [7:0]  BS_CHAR        = ASCII_BS,
  parameter bit          APPEND_CRLF    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 2812*10*16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     i_rx_data,
  input  logic                      i_rx_empty,
  output logic                      o_rx_read,
  output logic [DATA_WIDTH-1:0]     o_tx_data,
  output logic                      o_tx_write,
  input  logic                      i_tx_full,
  output logic                      o_busy,
  output logic [LINE_COUNT_W-1:0]   o_line_count,
  output logic                      o_overflow,
  output logic [$clog2(LINE_LEN):0] o_level
);

  localparam int unsigned AW    = $clog2(LINE_LEN);
  localparam int unsigned LVL_W = AW + 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_LAST  = LVL_W'(LINE_LEN - 1);

  state_e                  r_state;
  state_e                  r_gap_next;
  logic [DATA_WIDTH-1:0]   r_char;
  logic [LVL_W-1:0]        r_level;
  logic [LVL_W-1:0]        r_idx;
  logic                    r_eol;
  logic [TO_W-1:0]         r_tcnt;
  logic                    r_rx_read;
  logic                    r_tx_write;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic                    r_busy;
  logic [LINE_COUNT_W-1:0] r_line_count;
  logic                    r_overflow;

  logic                    w_is_bs;
  logic                    w_is_eol;
  logic                    w_we;
  logic [DATA_WIDTH-1:0]   w_rdata;

  assign w_is_bs  = (r_char == DATA_WIDTH'(BS_CHAR)) || (r_char == DATA_WIDTH'(ASCII_DEL));
  assign w_is_eol = (r_char == DATA_WIDTH'(EOL_CHAR));
  assign w_we     = (r_state == ST_RX_GAP) && !w_is_bs && !w_is_eol;

  // Read address follows idx, so data for idx+1 is fetched during the TX gap.
  uart_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_LEN   (LINE_LEN)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_level[AW-1:0]),
    .i_wdata (r_char),
    .i_raddr (r_idx[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_COLLECT;
      r_gap_next   <= ST_COLLECT;
      r_char       <= '0;
      r_level      <= '0;
      r_idx        <= '0;
      r_eol        <= 1'b0;
      r_tcnt       <= '0;
      r_rx_read    <= 1'b0;
      r_tx_write   <= 1'b0;
      r_tx_data    <= '0;
      r_busy       <= 1'b0;
      r_line_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_rx_read  <= 1'b0;
      r_tx_write <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (!i_rx_empty) begin
            r_char    <= i_rx_data;
            r_rx_read <= 1'b1;
            r_tcnt    <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_RX_GAP;
          end else if (r_level == '0) begin
            r_tcnt <= '0;
          end else if (TIMEOUT_CYCLES != 0) begin
            // Idle with a partial line: flush it once the line has sat long enough.
            if (r_tcnt == TO_LAST) begin
              r_tcnt  <= '0;
              r_eol   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= ST_FLUSH;
            end else begin
              r_tcnt <= r_tcnt + TO_W'(1);
            end
          end
        end

        ST_RX_GAP: begin
          if (w_is_bs) begin
            if (r_level != '0) begin
              r_level <= r_level - LVL_W'(1);
            end
            r_busy  <= 1'b0;
            r_state <= ST_COLLECT;
          end else if (w_is_eol) begin
            r_eol <= 1'b1;
            r_idx <= '0;
            if (r_level != '0) begin
              r_state <= ST_FLUSH;
            end else if (APPEND_CRLF) begin
              r_state <= ST_EOL_CR;
            end else begin
              r_state <= ST_DONE;
            end
          end else begin
            r_level <= r_level + LVL_W'(1);
            if (r_level == LVL_LAST) begin
              r_overflow <= 1'b1;
              r_eol      <= 1'b0;
              r_idx      <= '0;
              r_state    <= ST_FLUSH;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_COLLECT;
            end
          end
        end

        ST_FLUSH: begin
          if (!i_tx_full) begin
            r_tx_data  <= w_rdata;
            r_tx_write <= 1'b1;
            r_idx      <= r_idx + LVL_W'(1);
            r_state    <= ST_TX_GAP;
            if (r_idx + LVL_W'(1) != r_level) begin
              r_gap_next <= ST_FLUSH;
            end else if (r_eol && APPEND_CRLF) begin
              r_gap_next <= ST_EOL_CR;
            end else begin
              r_gap_next <= ST_DONE;
            end
          end
        end

        ST_TX_GAP: begin
          r_state <= r_gap_next;
        end

        ST_EOL_CR: begin
          if (!i_tx_full) begin
            r_tx_data  <= DATA_WIDTH'(ASCII_CR);
            r_tx_write <= 1'b1;
            r_gap_next <= ST_EOL_LF;
            r_state    <= ST_TX_GAP;
          end
        end

        ST_EOL_LF: begin
          if (!i_tx_full) begin
            r_tx_data  <= DATA_WIDTH'(ASCII_LF);
            r_tx_write <= 1'b1;
            r_gap_next <= ST_DONE;
            r_state    <= ST_TX_GAP;
          end
        end

        ST_DONE: begin
          r_line_count <= r_line_count + LINE_COUNT_W'(1);
          r_level      <= '0;
          r_idx        <= '0;
          r_eol        <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= ST_COLLECT;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_COLLECT;
        end
      endcase
    end
  end

  assign o_rx_read    = r_rx_read;
  assign o_tx_write   = r_tx_write;
  assign o_tx_data    = r_tx_data;
  assign o_busy       = r_busy;
  assign o_line_count = r_line_count;
  assign o_overflow   = r_overflow;
  assign o_level      = r_level;

endmodule

// File: tb/tb_uart_line_assembler.sv
// Bench for uart_line_assembler: directed cases plus random traffic checked
// against a queue-based line-editing model of the expected TX byte stream.
`timescale 1ns/1ps
module tb_uart_line_assembler;

  localparam int unsigned DW = 8;
  localparam int unsigned LL = 8;
  localparam int unsigned TO = 100;
  localparam int unsigned LW = $clog2(LL) + 1;
  localparam int          IDLE_LIMIT = 5000;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] i_rx_data;
  logic          i_rx_empty;
  logic          o_rx_read;
  logic [DW-1:0] o_tx_data;
  logic          o_tx_write;
  logic          i_tx_full;
  logic          o_busy;
  logic [15:0]   o_line_count;
  logic          o_overflow;
  logic [LW-1:0] o_level;

  uart_line_assembler #(
    .DATA_WIDTH     (DW),
    .LINE_LEN       (LL),
    .EOL_CHAR       (8'h0D),
    .BS_CHAR        (8'h08),
    .APPEND_CRLF    (1'b1),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_data    (i_rx_data),
    .i_rx_empty   (i_rx_empty),
    .o_rx_read    (o_rx_read),
    .o_tx_data    (o_tx_data),
    .o_tx_write   (o_tx_write),
    .i_tx_full    (i_tx_full),
    .o_busy       (o_busy),
    .o_line_count (o_line_count),
    .o_overflow   (o_overflow),
    .o_level      (o_level)
  );

  always #5 clk = ~clk;

  bq_t         rx_q, exp_q, tx_log, m_line;
  int unsigned m_lines;
  bit          m_ovf;
  int          n_vec, n_err;
  bit          full_force, full_rand, prev_full;

  function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Model: line editing rules applied to the whole input stream.
  function automatic void m_emit(input bit eol);
    foreach (m_line[i]) exp_q.push_back(m_line[i]);
    if (eol) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    m_line.delete();
    m_lines++;
  endfunction

  function automatic void m_feed(input logic [7:0] c);
    if (c == 8'h08 || c == 8'h7F) begin
      if (m_line.size() > 0) void'(m_line.pop_back());
    end else if (c == 8'h0D) begin
      m_emit(1'b1);
    end else begin
      m_line.push_back(c);
      if (m_line.size() == LL) begin
        m_ovf = 1'b1;
        m_emit(1'b0);
      end
    end
  endfunction

  function automatic void m_timeout();
    if (m_line.size() > 0) m_emit(1'b0);
  endfunction

  // RX FIFO model, TX FIFO full driver and per-write compare.
  always @(negedge clk) begin
    if (rst_n && o_tx_write) begin
      chk("tx_write_on_full", 32'(prev_full), 32'd0);
      tx_log.push_back(o_tx_data);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tx: got %02h expected no write", o_tx_data);
      end else begin
        chk("tx_data", 32'(o_tx_data), 32'(exp_q.pop_front()));
      end
    end
    if (rst_n && o_rx_read) begin
      if (rx_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_empty: got rx_read=1 expected 0 with empty FIFO");
      end else begin
        void'(rx_q.pop_front());
      end
    end
    i_rx_empty = (rx_q.size() == 0);
    i_rx_data  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    i_tx_full  = full_force | (full_rand && ($urandom_range(0, 9) < 3));
    prev_full  = i_tx_full;
  end

  task automatic send(input bq_t s);
    foreach (s[i]) begin
      rx_q.push_back(s[i]);
      m_feed(s[i]);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    m_timeout();
    repeat (2) @(negedge clk);
    while (!(rx_q.size() == 0 && exp_q.size() == 0 && !o_busy && o_level == '0) && n < IDLE_LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_reached"}, 32'(n < IDLE_LIMIT), 32'd1);
    chk({name, "_line_count"}, 32'(o_line_count), 32'(m_lines[15:0]));
    chk({name, "_overflow"}, 32'(o_overflow), 32'(m_ovf));
    chk({name, "_level"}, 32'(o_level), 32'd0);
  endtask

  task automatic chk_log(input string name, input bq_t lit);
    chk({name, "_len"}, 32'(tx_log.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size() && i < tx_log.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), 32'(tx_log[i]), 32'(lit[i]));
  endtask

  task automatic wait_writes(input string name, input int want);
    int seen;
    seen = 0;
    for (int i = 0; i < 300 && seen < want; i++) begin
      @(negedge clk);
      if (o_tx_write) seen++;
    end
    chk(name, 32'(seen), 32'(want));
  endtask

  initial begin
    bq_t s;
    int  ip, iw, pops, pop_cr;
    int  wr[$];
    full_force = 1'b0;
    full_rand  = 1'b0;
    prev_full  = 1'b0;
    i_rx_empty = 1'b1;
    i_rx_data  = '0;
    i_tx_full  = 1'b0;
    m_lines    = 0;
    m_ovf      = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rx_read", 32'(o_rx_read), 32'd0);
    chk("rst_tx_write", 32'(o_tx_write), 32'd0);
    chk("rst_tx_data", 32'(o_tx_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_line_count", 32'(o_line_count), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // HELLO + CR
    tx_log.delete();
    s = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D};
    send(s);
    wait_idle("hello");
    s = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};
    chk_log("hello", s);
    chk("hello_lines_lit", 32'(o_line_count), 32'd1);

    // Backspace editing mid-line
    tx_log.delete();
    s = '{8'h41, 8'h42, 8'h08, 8'h43, 8'h0D};
    send(s);
    wait_idle("bs_mid");
    s = '{8'h41, 8'h43, 8'h0D, 8'h0A};
    chk_log("bs_mid", s);

    // Leading backspaces must not underflow level
    tx_log.delete();
    s = '{8'h08, 8'h08};
    send(s);
    repeat (10) @(negedge clk);
    chk("bs_lead_level", 32'(o_level), 32'd0);
    s = '{8'h41, 8'h0D};
    send(s);
    wait_idle("bs_lead");
    s = '{8'h41, 8'h0D, 8'h0A};
    chk_log("bs_lead", s);

    // Buffer full flush without CRLF, then remainder
    tx_log.delete();
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h0D};
    send(s);
    wait_idle("ovf");
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h0D, 8'h0A};
    chk_log("ovf", s);
    chk("ovf_flag_lit", 32'(o_overflow), 32'd1);
    chk("ovf_lines_lit", 32'(o_line_count), 32'd5);

    // Latency and throughput for 'A' CR
    s = '{8'h41, 8'h0D};
    send(s);
    pops = 0;
    pop_cr = -1;
    for (int i = 0; i < 60 && wr.size() < 3; i++) begin
      @(negedge clk);
      if (o_rx_read) begin
        pops++;
        if (pops == 2) pop_cr = i;
      end
      if (o_tx_write) wr.push_back(i);
    end
    chk("lat_writes", 32'(wr.size()), 32'd3);
    if (wr.size() == 3 && pop_cr >= 0) begin
      chk("lat_first_write", 32'(wr[0] - pop_cr), 32'd2);
      chk("lat_spacing_1", 32'(wr[1] - wr[0]), 32'd2);
      chk("lat_spacing_2", 32'(wr[2] - wr[1]), 32'd2);
    end
    wait_idle("lat");

    // TX FIFO full for 20 cycles mid-line
    tx_log.delete();
    s = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D};
    send(s);
    wait_writes("stall_pre_writes", 2);
    full_force = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_no_write", 32'(o_tx_write), 32'd0);
    end
    full_force = 1'b0;
    wait_idle("stall");
    s = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    chk_log("stall", s);

    // Idle timeout flushes a partial line without CRLF
    tx_log.delete();
    s = '{8'h5A};
    send(s);
    m_timeout();
    ip = -1;
    iw = -1;
    for (int i = 0; i < 400 && iw < 0; i++) begin
      @(negedge clk);
      if (o_rx_read && ip < 0) ip = i;
      if (ip >= 0 && i == ip + 5) begin
        chk("to_level_held", 32'(o_level), 32'd1);
        chk("to_busy_low", 32'(o_busy), 32'd0);
      end
      if (o_tx_write) iw = i;
    end
    chk("to_fired", 32'(iw >= 0), 32'd1);
    if (iw >= 0 && ip >= 0) chk("to_latency", 32'(iw - ip), 32'd102);
    wait_idle("timeout");
    s = '{8'h5A};
    chk_log("timeout", s);

    // Asynchronous reset while stalled in the CR phase
    tx_log.delete();
    s = '{8'h41, 8'h42, 8'h0D};
    send(s);
    wait_writes("rst_pre_writes", 2);
    full_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_busy", 32'(o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rx_read", 32'(o_rx_read), 32'd0);
    chk("arst_tx_write", 32'(o_tx_write), 32'd0);
    chk("arst_tx_data", 32'(o_tx_data), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_line_count", 32'(o_line_count), 32'd0);
    chk("arst_overflow", 32'(o_overflow), 32'd0);
    chk("arst_level", 32'(o_level), 32'd0);
    exp_q.delete();
    m_line.delete();
    m_lines = 0;
    m_ovf = 1'b0;
    full_force = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tx_log.delete();
    s = '{8'h58, 8'h0D};
    send(s);
    wait_idle("post_rst");
    s = '{8'h58, 8'h0D, 8'h0A};
    chk_log("post_rst", s);
    chk("post_rst_lines_lit", 32'(o_line_count), 32'd1);

    // Random traffic with random TX back-pressure
    full_rand = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      int unsigned len;
      s.delete();
      len = $urandom_range(10, 40);
      for (int k = 0; k < int'(len); k++) begin
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 6)       s.push_back(8'h08);
        else if (r < 10) s.push_back(8'h7F);
        else if (r < 22) s.push_back(8'h0D);
        else             s.push_back(8'($urandom_range(32'h20, 32'h7E)));
      end
      send(s);
      wait_idle($sformatf("rand%0d", seg));
    end
    full_rand = 1'b0;

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
